// File: rtl/serial_adder_pkg.sv
// Shared constants and state encoding for the bit-serial adder/subtractor.
package serial_adder_pkg;

  // Default operand/result width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states: waiting, shifting bits, one-cycle result strobe.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// One-bit adder cells: a half adder and a full adder built from two of them.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i;
  assign cout_o = a_i & b_i;

endmodule : half_adder

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic s1_s;
  logic c1_s;
  logic c2_s;

  half_adder u_ha0 (
    .a_i    (a_i),
    .b_i    (b_i),
    .sum_o  (s1_s),
    .cout_o (c1_s)
  );

  half_adder u_ha1 (
    .a_i    (s1_s),
    .b_i    (cin_i),
    .sum_o  (sum_o),
    .cout_o (c2_s)
  );

  // At most one of the two half adders can generate a carry.
  assign cout_o = c1_s | c2_s;

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles
// per operation, registered results with a one-cycle done strobe.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q;
  logic             done_q;

  logic             fa_s_s;
  logic             fa_c_s;
  logic [WIDTH-1:0] acc_shift_s;
  logic [WIDTH-1:0] ld_b_s;
  logic             ld_carry_s;

  full_adder u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_s_s),
    .cout_o (fa_c_s)
  );

  // Subtraction is a + ~b + 1, so the inverted operand and forced carry are
  // prepared here and loaded on start.
  assign ld_b_s     = sub ? ~b : b;
  assign ld_carry_s = sub ? 1'b1 : cin;

  // New sum bit enters at the MSB; after WIDTH shifts it lands at bit 0.
  assign acc_shift_s = (acc_q >> 1) | (WIDTH'(fa_s_s) << (WIDTH - 1));

  // Next-state and datapath control; every register holds by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = ld_b_s;
          carry_d = ld_carry_s;
          acc_d   = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        acc_d   = acc_shift_s;
        carry_d = fa_c_s;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB.
          state_d = DONE;
          sum_d   = acc_shift_s;
          cout_d  = fa_c_s;
          ovf_d   = carry_q ^ fa_c_s;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): transaction-level model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int           m_left = 0;     // RUN cycles still to go
  bit           m_done = 1'b0;
  logic [W-1:0] m_sum = '0, p_sum = '0;
  logic         m_cout = 1'b0, p_cout = 1'b0;
  logic         m_ovf = 1'b0, p_ovf = 1'b0;

  // Result by plain arithmetic; signed overflow from operand/result signs.
  task automatic model_compute(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic tc, input logic ts);
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = ts ? ~tb_v : tb_v;
    full = {1'b0, ta} + {1'b0, bb} + ((ts ? 1'b1 : tc) ? 9'd1 : 9'd0);
    p_sum  = full[W-1:0];
    p_cout = full[W];
    p_ovf  = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0;
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        model_compute(a, b, cin, sub);
        m_left = W;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_done));
      check("busy_and_done", 32'(busy & done), 32'd0);
      check("sum", 32'(sum), 32'(m_sum));
      check("cout", 32'(cout), 32'(m_cout));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(input string nm, input int exp_lat);
    int n;
    bit got;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    check({nm, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input logic ts);
    @(posedge clk); #1;
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    issue(ta, tb_v, tc, ts);
    wait_done(nm, 9);
    check({nm, "_sum"}, 32'(sum), 32'(es));
    check({nm, "_cout"}, 32'(cout), 32'(ec));
    check({nm, "_ovf"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    int dn;
    // Reset for two cycles.
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sum", 32'(sum), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    run_op("add",      8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
    run_op("carry",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("ovf",      8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_neg",  8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("add_cin",  8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);

    // Start during RUN (cycle 3) must be ignored.
    issue(8'h11, 8'h22, 1'b0, 1'b0);
    @(posedge clk); #1;
    a = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign", 7);
    check("ign_sum", 32'(sum), 32'h33);

    // Start held during the done cycle: back-to-back acceptance.
    issue(8'h3C, 8'h0F, 1'b0, 1'b0);
    wait_done("b2b_first", 9);
    a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_hold", 32'(sum), 32'h4B);
    wait_done("b2b_second", 8);
    check("b2b_sum", 32'(sum), 32'h02);

    // Reset at RUN cycle 4 aborts the operation.
    issue(8'h3C, 8'h0F, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_sum", 32'(sum), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    run_op("after_abort", 8'h0A, 8'h05, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor. It accepts two WIDTH-bit operands with a start handshake and processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It reports sum, carry-out and signed overflow with a one-cycle done pulse. It is the sequential, width-generic successor to the combinational half adder and suits area-constrained datapaths where WIDTH cycles of latency are acceptable.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 1
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- sub  input  1  0 = a+b+cin, 1 = a−b (b inverted, carry-in forced to 1, cin ignored); captured with start
- a  input  WIDTH  operand A; captured with start
- b  input  WIDTH  operand B; captured with start
- cin  input  1  carry-in for add mode; captured with start
- sum  output  WIDTH  result register
- cout  output  1  carry-out of MSB; in sub mode, 1 = no borrow
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse; results valid from this cycle on

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on start=1.
  - RUN → DONE when the bit counter reaches WIDTH−1 and that bit is processed.
  - DONE → RUN on start=1, otherwise DONE → IDLE.
- On start acceptance:
  - Load shift registers with a and (sub ? ~b : b).
  - Load carry flop with (sub ? 1 : cin).
  - Clear the bit counter. Counter width is $clog2(WIDTH+1).
- Each RUN cycle:
  - full_adder(a_sh[0], b_sh[0], carry) yields s and c.
  - s shifts into the MSB of the internal sum shift register.
  - Operand registers shift right; carry ← c; counter increments.
  - Before the last bit is processed, the carry flop value is saved as carry-into-MSB.
- On RUN → DONE: load sum, cout and overflow output registers from the internal shift register, final carry and saved carry-into-MSB.
- Outputs hold their last result through IDLE and through a subsequent RUN. They change only at the next RUN → DONE transition or at reset.
- start while in RUN is ignored; captured operands are unaffected.
- WIDTH=1: a single RUN cycle; overflow = cin-to-bit0 XOR cout.

## Timing
- Reset (rst=1 at an edge), next cycle:
  - state=IDLE
  - sum=0, cout=0, overflow=0, busy=0, done=0
  - counter, carry and shift registers = 0
- Reset has priority over start and applies in any state. Reset mid-RUN aborts the operation: no done pulse, outputs cleared.
- Edge E0 samples start=1 in IDLE or DONE. busy=1 for the WIDTH cycles following E0.
- Edge E0+WIDTH performs RUN → DONE:
  - done=1 and busy=0 in the cycle after that edge.
  - Latency from the start edge to the done cycle is WIDTH+1 cycles.
- done falls after exactly one cycle, except when a new start is accepted in DONE. In that case done=0 and busy=1 on the next cycle, giving a throughput of one operation per WIDTH+1 cycles.
- busy and done are never high simultaneously.

## Structure
- Package serial_adder_pkg holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - the default WIDTH constant
- One sub-module: full_adder (a, b, cin → sum, cout), built from two half_adder instances plus an OR gate. It is instantiated once in serial_adder.
- Next-state/control logic and the datapath shift registers live in serial_adder.

## Test plan
All scenarios use WIDTH=8.
- Reset:
  - Stimulus: rst=1 for 2 cycles, then 0.
  - Required: sum=8'h00, cout=0, overflow=0, busy=0, done=0; remains IDLE with start=0.
- Add:
  - Stimulus: a=8'h3C, b=8'h0F, cin=0, sub=0, start pulse.
  - Required: busy high 8 cycles, done pulse on cycle 9; sum=8'h4B, cout=0, overflow=0.
- Carry and overflow:
  - Stimulus: 8'hFF+8'h01. Required: sum=8'h00, cout=1, overflow=0.
  - Stimulus: 8'h7F+8'h01. Required: sum=8'h80, cout=0, overflow=1.
- Subtract:
  - Stimulus: sub=1, 8'h05−8'h07. Required: sum=8'hFE, cout=0, overflow=0.
  - Stimulus: sub=1, 8'h80−8'h01. Required: sum=8'h7F, cout=1, overflow=1.
  - cin is ignored in both cases.
- Handshake:
  - Stimulus: start with a=8'h11, b=8'h22, then start again at RUN cycle 3 with a=8'hFF.
  - Required: second start ignored; sum=8'h33.
  - Stimulus: start held during the done cycle with 8'h01+8'h01.
  - Required: accepted; next done 9 cycles later with sum=8'h02; previous result held until then.
- Reset mid-operation:
  - Stimulus: rst=1 at RUN cycle 4.
  - Required: next cycle all outputs 0, IDLE, no done pulse; a following start of 8'h0A+8'h05 gives sum=8'h0F.
